// File: rtl/color_window_buffer_pkg.sv
// Shared constants, byte type and leading-valid counter for the colour window buffer.
package color_buf_pkg;

   localparam int unsigned DEF_NUM_CH       = 3;
   localparam int unsigned DEF_WORDS_PER_CH = 2;
   localparam int unsigned DEF_WORD_BYTES   = 2;
   localparam int unsigned DEF_WIN_BYTES    = 3;
   localparam int unsigned DEF_LOW_WM       = 3;
   localparam int unsigned DEF_DATA_W       = 32;
   localparam int unsigned MAX_D            = 64;

   typedef logic [7:0] byte_t;

   // Number of contiguous set bits starting at bit 0, limited to the first n bits.
   function automatic int unsigned lead_count(input logic [MAX_D-1:0] mask, input int unsigned n);
      int unsigned cnt;
      logic        run;
      cnt = 0;
      run = 1'b1;
      for (int unsigned i = 0; i < MAX_D; i++) begin
         if (run && (i < n) && mask[i]) cnt = cnt + 1;
         else                           run = 1'b0;
      end
      return cnt;
   endfunction

endpackage

// File: rtl/color_window_buffer_if.sv
// Store/shift/window bundle between the colour producer-consumer and the buffer.
interface color_window_buffer_if
   import color_buf_pkg::*;
#(
   parameter int unsigned NUM_CH       = DEF_NUM_CH,
   parameter int unsigned WORDS_PER_CH = DEF_WORDS_PER_CH,
   parameter int unsigned WORD_BYTES   = DEF_WORD_BYTES,
   parameter int unsigned WIN_BYTES    = DEF_WIN_BYTES,
   parameter int unsigned DATA_W       = DEF_DATA_W
);
   localparam int unsigned AW = $clog2(NUM_CH*WORDS_PER_CH);
   localparam int unsigned SW = $clog2(WIN_BYTES+1);

   logic                                 we;
   logic [AW-1:0]                        address;
   logic [DATA_W-1:0]                    di;
   logic                                 sh_req;
   logic [SW-1:0]                        sh_amt;
   logic                                 clr;
   logic                                 sh_ack;
   logic                                 wr_drop;
   logic                                 addr_err;
   logic [NUM_CH-1:0][8*WIN_BYTES-1:0]   win_out;
   logic [NUM_CH-1:0]                    win_valid;
   logic [NUM_CH-1:0]                    fill_req;

   modport master (
      output we, address, di, sh_req, sh_amt, clr,
      input  sh_ack, wr_drop, addr_err, win_out, win_valid, fill_req
   );

   modport slave (
      input  we, address, di, sh_req, sh_amt, clr,
      output sh_ack, wr_drop, addr_err, win_out, win_valid, fill_req
   );

endinterface

// File: rtl/color_window_buffer_chan_queue.sv
// One colour channel: byte storage with valid mask, shift-by-n, word write, level flags.
module color_chan_queue
   import color_buf_pkg::*;
#(
   parameter int unsigned WORDS_PER_CH = DEF_WORDS_PER_CH,
   parameter int unsigned WORD_BYTES   = DEF_WORD_BYTES,
   parameter int unsigned WIN_BYTES    = DEF_WIN_BYTES,
   parameter int unsigned LOW_WM       = DEF_LOW_WM,
   parameter int unsigned D            = WORDS_PER_CH*WORD_BYTES,
   parameter int unsigned SW           = $clog2(WIN_BYTES+1),
   parameter int unsigned WIW          = 1,
   parameter int unsigned LW           = $clog2(D+1)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr_i,
   input  logic                     sh_i,
   input  logic [SW-1:0]            sh_amt_i,
   input  logic                     wr_i,
   input  logic [WIW-1:0]           word_i,
   input  logic [8*WORD_BYTES-1:0]  wdata_i,
   output logic [8*WIN_BYTES-1:0]   win_o,
   output logic [LW-1:0]            lvl_o,
   output logic                     win_valid_o,
   output logic                     fill_req_o
);
   byte_t [D-1:0] data_q, data_d;
   logic  [D-1:0] mask_q, mask_d;
   logic  [LW-1:0] lvl_q;
   logic          win_valid_q, fill_req_q;
   int unsigned   shamt, base, lcnt;

   assign shamt = 32'(sh_amt_i);
   assign base  = 32'(word_i) * WORD_BYTES;

   // Priority clr > shift > write; the top only asserts sh_i/wr_i when allowed.
   always_comb begin
      data_d = data_q;
      mask_d = mask_q;
      if (clr_i) begin
         mask_d = '0;
      end else if (sh_i) begin
         for (int unsigned i = 0; i < D; i++) begin
            if (i + shamt < D) begin
               data_d[i] = data_q[i + shamt];
               mask_d[i] = mask_q[i + shamt];
            end else begin
               data_d[i] = '0;
               mask_d[i] = 1'b0;
            end
         end
      end else if (wr_i) begin
         for (int unsigned b = 0; b < WORD_BYTES; b++) begin
            data_d[base + b] = wdata_i[8*(WORD_BYTES-1-b) +: 8];
            mask_d[base + b] = 1'b1;
         end
      end
   end

   assign lcnt = lead_count(MAX_D'(mask_d), D);

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q      <= '0;
         mask_q      <= '0;
         lvl_q       <= '0;
         win_valid_q <= 1'b0;
         fill_req_q  <= 1'b1;
      end else begin
         data_q      <= data_d;
         mask_q      <= mask_d;
         lvl_q       <= LW'(lcnt);
         win_valid_q <= (lcnt >= WIN_BYTES);
         fill_req_q  <= (lcnt <= LOW_WM);
      end
   end

   // Head byte lands in the window MSBs.
   always_comb begin
      win_o = '0;
      for (int unsigned k = 0; k < WIN_BYTES; k++) win_o[8*(WIN_BYTES-1-k) +: 8] = data_q[k];
   end

   assign lvl_o       = lvl_q;
   assign win_valid_o = win_valid_q;
   assign fill_req_o  = fill_req_q;

endmodule

// File: rtl/color_window_buffer.sv
// Multi-channel sliding colour window: address decode, all-channel shift gating, status pulses.
module color_window_buffer
   import color_buf_pkg::*;
#(
   parameter int unsigned NUM_CH       = DEF_NUM_CH,
   parameter int unsigned WORDS_PER_CH = DEF_WORDS_PER_CH,
   parameter int unsigned WORD_BYTES   = DEF_WORD_BYTES,
   parameter int unsigned WIN_BYTES    = DEF_WIN_BYTES,
   parameter int unsigned LOW_WM       = DEF_LOW_WM,
   parameter int unsigned DATA_W       = DEF_DATA_W
) (
   input  logic                  clk,
   input  logic                  rst,
   color_window_buffer_if.slave  bus
);
   localparam int unsigned D   = WORDS_PER_CH*WORD_BYTES;
   localparam int unsigned NW  = NUM_CH*WORDS_PER_CH;
   localparam int unsigned SW  = $clog2(WIN_BYTES+1);
   localparam int unsigned WW  = 8*WORD_BYTES;
   localparam int unsigned LW  = $clog2(D+1);
   localparam int unsigned WIW = (WORDS_PER_CH > 1) ? $clog2(WORDS_PER_CH) : 1;

   logic [NUM_CH-1:0][LW-1:0] lvl;
   logic [NUM_CH-1:0]         wr_en;
   logic                      amt_ok, all_ok, fire, in_range, wr_go;
   logic                      sh_ack_q, wr_drop_q, addr_err_q;
   logic                      sh_ack_d, wr_drop_d, addr_err_d;
   int unsigned               addr_u, ch_idx, word_idx;

   assign addr_u   = 32'(bus.address);
   assign ch_idx   = addr_u / WORDS_PER_CH;
   assign word_idx = addr_u % WORDS_PER_CH;
   assign in_range = (addr_u < NW);

   // A shift fires only when every channel holds at least sh_amt leading valid bytes.
   always_comb begin
      amt_ok = bus.sh_req && (bus.sh_amt != '0) && (32'(bus.sh_amt) <= WIN_BYTES);
      all_ok = 1'b1;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         if (32'(lvl[c]) < 32'(bus.sh_amt)) all_ok = 1'b0;
      end
      fire       = amt_ok && all_ok && !bus.clr;
      wr_go      = bus.we && !bus.clr && !fire && in_range;
      sh_ack_d   = fire;
      wr_drop_d  = bus.we && (bus.clr || fire);
      addr_err_d = bus.we && !bus.clr && !fire && !in_range;
      wr_en      = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         if (wr_go && (ch_idx == c)) wr_en[c] = 1'b1;
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
      color_chan_queue #(
         .WORDS_PER_CH (WORDS_PER_CH),
         .WORD_BYTES   (WORD_BYTES),
         .WIN_BYTES    (WIN_BYTES),
         .LOW_WM       (LOW_WM),
         .D            (D),
         .SW           (SW),
         .WIW          (WIW),
         .LW           (LW)
      ) u_chan (
         .clk         (clk),
         .rst         (rst),
         .clr_i       (bus.clr),
         .sh_i        (fire),
         .sh_amt_i    (bus.sh_amt),
         .wr_i        (wr_en[g]),
         .word_i      (WIW'(word_idx)),
         .wdata_i     (bus.di[WW-1:0]),
         .win_o       (bus.win_out[g]),
         .lvl_o       (lvl[g]),
         .win_valid_o (bus.win_valid[g]),
         .fill_req_o  (bus.fill_req[g])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sh_ack_q   <= 1'b0;
         wr_drop_q  <= 1'b0;
         addr_err_q <= 1'b0;
      end else begin
         sh_ack_q   <= sh_ack_d;
         wr_drop_q  <= wr_drop_d;
         addr_err_q <= addr_err_d;
      end
   end

   assign bus.sh_ack   = sh_ack_q;
   assign bus.wr_drop  = wr_drop_q;
   assign bus.addr_err = addr_err_q;

endmodule

// File: tb/tb_color_window_buffer.sv
// Directed bench: default 3-channel buffer plus a 4-channel/4-byte-word variant.
module tb_color_window_buffer;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   color_window_buffer_if #(.NUM_CH(3), .WORDS_PER_CH(2), .WORD_BYTES(2), .WIN_BYTES(3), .DATA_W(32)) bus_a ();
   color_window_buffer_if #(.NUM_CH(4), .WORDS_PER_CH(2), .WORD_BYTES(4), .WIN_BYTES(4), .DATA_W(32)) bus_b ();

   color_window_buffer #(.NUM_CH(3), .WORDS_PER_CH(2), .WORD_BYTES(2), .WIN_BYTES(3), .LOW_WM(3), .DATA_W(32))
      u_dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));

   color_window_buffer #(.NUM_CH(4), .WORDS_PER_CH(2), .WORD_BYTES(4), .WIN_BYTES(4), .LOW_WM(3), .DATA_W(32))
      u_dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_a();
      bus_a.we = 1'b0; bus_a.address = '0; bus_a.di = '0;
      bus_a.sh_req = 1'b0; bus_a.sh_amt = '0; bus_a.clr = 1'b0;
   endtask

   task automatic idle_b();
      bus_b.we = 1'b0; bus_b.address = '0; bus_b.di = '0;
      bus_b.sh_req = 1'b0; bus_b.sh_amt = '0; bus_b.clr = 1'b0;
   endtask

   task automatic wr_a(input int a, input logic [31:0] d);
      bus_a.we = 1'b1; bus_a.address = 3'(a); bus_a.di = d;
      tick();
      idle_a();
   endtask

   task automatic sh_a(input int n);
      bus_a.sh_req = 1'b1; bus_a.sh_amt = 2'(n);
      tick();
      idle_a();
   endtask

   task automatic wr_b(input int a, input logic [31:0] d);
      bus_b.we = 1'b1; bus_b.address = 3'(a); bus_b.di = d;
      tick();
      idle_b();
   endtask

   task automatic sh_b(input int n);
      bus_b.sh_req = 1'b1; bus_b.sh_amt = 3'(n);
      tick();
      idle_b();
   endtask

   initial begin
      logic [31:0] b_words [8];
      b_words = '{32'h10203040, 32'h50607080, 32'h11111111, 32'h22222222,
                  32'h33333333, 32'h44444444, 32'hDEADBEEF, 32'h01020304};
      idle_a();
      idle_b();
      rst = 1'b1;
      @(negedge clk);
      tick();
      rst = 1'b0;
      tick();

      check_eq("rst_win",    64'(bus_a.win_out),   64'h0);
      check_eq("rst_valid",  64'(bus_a.win_valid), 64'h0);
      check_eq("rst_fill",   64'(bus_a.fill_req),  64'h7);
      check_eq("rst_pulses", 64'({bus_a.sh_ack, bus_a.wr_drop, bus_a.addr_err}), 64'h0);

      wr_a(0, 32'h1122); wr_a(1, 32'h3344); wr_a(2, 32'h5566);
      wr_a(3, 32'h7788); wr_a(4, 32'h99AA); wr_a(5, 32'hBBCC);
      check_eq("load_win0",  64'(bus_a.win_out[0]), 64'h112233);
      check_eq("load_win1",  64'(bus_a.win_out[1]), 64'h556677);
      check_eq("load_win2",  64'(bus_a.win_out[2]), 64'h99AABB);
      check_eq("load_valid", 64'(bus_a.win_valid), 64'h7);
      check_eq("load_fill",  64'(bus_a.fill_req),  64'h0);
      check_eq("load_flags", 64'({bus_a.wr_drop, bus_a.addr_err}), 64'h0);

      sh_a(0);
      check_eq("amt0_ack", 64'(bus_a.sh_ack), 64'h0);
      check_eq("amt0_win", 64'(bus_a.win_out[0]), 64'h112233);

      sh_a(1);
      check_eq("sh1_ack",   64'(bus_a.sh_ack), 64'h1);
      check_eq("sh1_win0",  64'(bus_a.win_out[0]), 64'h223344);
      check_eq("sh1_win2",  64'(bus_a.win_out[2]), 64'hAABBCC);
      check_eq("sh1_fill",  64'(bus_a.fill_req),  64'h7);
      check_eq("sh1_valid", 64'(bus_a.win_valid), 64'h7);

      sh_a(3);
      check_eq("sh3_ack",   64'(bus_a.sh_ack), 64'h1);
      check_eq("sh3_valid", 64'(bus_a.win_valid), 64'h0);
      check_eq("sh3_fill",  64'(bus_a.fill_req),  64'h7);
      check_eq("sh3_win0",  64'(bus_a.win_out[0]), 64'h0);

      sh_a(1);
      check_eq("empty_stall", 64'(bus_a.sh_ack), 64'h0);

      wr_a(0, 32'hA1A2); wr_a(1, 32'hA3A4); wr_a(2, 32'hB1B2); wr_a(3, 32'hB3B4);
      sh_a(2);
      check_eq("part_stall", 64'(bus_a.sh_ack), 64'h0);
      check_eq("part_win0",  64'(bus_a.win_out[0]), 64'hA1A2A3);
      check_eq("part_win1",  64'(bus_a.win_out[1]), 64'hB1B2B3);
      check_eq("part_valid", 64'(bus_a.win_valid), 64'h3);
      check_eq("part_fill",  64'(bus_a.fill_req),  64'h4);

      wr_a(4, 32'hC1C2);
      sh_a(2);
      check_eq("ch2_sh_ack", 64'(bus_a.sh_ack), 64'h1);
      check_eq("ch2_win0",   64'(bus_a.win_out[0]), 64'hA3A400);
      check_eq("ch2_win1",   64'(bus_a.win_out[1]), 64'hB3B400);

      bus_a.we = 1'b1; bus_a.address = 3'd5; bus_a.di = 32'hD1D2;
      bus_a.sh_req = 1'b1; bus_a.sh_amt = 2'd1;
      tick();
      idle_a();
      check_eq("stallwr_ack",  64'(bus_a.sh_ack),  64'h0);
      check_eq("stallwr_drop", 64'(bus_a.wr_drop), 64'h0);
      check_eq("stallwr_win2", 64'(bus_a.win_out[2]), 64'h0000D1);

      wr_a(6, 32'hFFFF);
      check_eq("oor_err",  64'(bus_a.addr_err), 64'h1);
      check_eq("oor_drop", 64'(bus_a.wr_drop),  64'h0);
      check_eq("oor_win0", 64'(bus_a.win_out[0]), 64'hA3A400);
      check_eq("oor_win2", 64'(bus_a.win_out[2]), 64'h0000D1);

      wr_a(4, 32'hE1E2);
      bus_a.we = 1'b1; bus_a.address = 3'd0; bus_a.di = 32'h7777;
      bus_a.sh_req = 1'b1; bus_a.sh_amt = 2'd1;
      tick();
      idle_a();
      check_eq("collide_ack",  64'(bus_a.sh_ack),  64'h1);
      check_eq("collide_drop", 64'(bus_a.wr_drop), 64'h1);
      check_eq("collide_win0", 64'(bus_a.win_out[0]), 64'hA40000);
      check_eq("collide_win2", 64'(bus_a.win_out[2]), 64'hE2D1D2);

      bus_a.clr = 1'b1; bus_a.we = 1'b1; bus_a.address = 3'd1; bus_a.di = 32'h5555;
      bus_a.sh_req = 1'b1; bus_a.sh_amt = 2'd1;
      tick();
      idle_a();
      check_eq("clr_drop",  64'(bus_a.wr_drop), 64'h1);
      check_eq("clr_ack",   64'(bus_a.sh_ack),  64'h0);
      check_eq("clr_valid", 64'(bus_a.win_valid), 64'h0);
      check_eq("clr_fill",  64'(bus_a.fill_req),  64'h7);
      check_eq("clr_win0",  64'(bus_a.win_out[0]), 64'hA40000);
      tick();
      check_eq("pulse_clear", 64'({bus_a.sh_ack, bus_a.wr_drop, bus_a.addr_err}), 64'h0);

      for (int i = 0; i < 8; i++) wr_b(i, b_words[i]);
      check_eq("b_load_win3",  64'(bus_b.win_out[3]), 64'hDEADBEEF);
      check_eq("b_load_valid", 64'(bus_b.win_valid), 64'hF);
      check_eq("b_load_fill",  64'(bus_b.fill_req),  64'h0);

      sh_b(4);
      check_eq("b_sh4_ack",   64'(bus_b.sh_ack), 64'h1);
      check_eq("b_sh4_win3",  64'(bus_b.win_out[3]), 64'h01020304);
      check_eq("b_sh4_win0",  64'(bus_b.win_out[0]), 64'h50607080);
      check_eq("b_sh4_win1",  64'(bus_b.win_out[1]), 64'h22222222);
      check_eq("b_sh4_win2",  64'(bus_b.win_out[2]), 64'h44444444);
      check_eq("b_sh4_valid", 64'(bus_b.win_valid), 64'hF);
      check_eq("b_sh4_fill",  64'(bus_b.fill_req),  64'h0);

      sh_b(5);
      check_eq("b_amt5_ack",  64'(bus_b.sh_ack), 64'h0);
      check_eq("b_amt5_win3", 64'(bus_b.win_out[3]), 64'h01020304);

      rst = 1'b1;
      bus_b.sh_req = 1'b1; bus_b.sh_amt = 3'd4;
      tick();
      rst = 1'b0;
      idle_b();
      check_eq("b_rst_win3",  64'(bus_b.win_out[3]), 64'h0);
      check_eq("b_rst_ack",   64'(bus_b.sh_ack),  64'h0);
      check_eq("b_rst_fill",  64'(bus_b.fill_req), 64'hF);
      check_eq("b_rst_valid", 64'(bus_b.win_valid), 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
